// File: rtl/move_select_ctrl_pkg.sv
// Shared chess definitions for the move-selection controller: piece/colour codes,
// square-index field helpers and the selection FSM state encoding.
package move_select_ctrl_pkg;

  localparam logic [2:0] PIECE_NONE   = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef enum logic [1:0] {
    SEL_SRC = 2'd0,
    SEL_DST = 2'd1,
    ISSUE   = 2'd2
  } state_t;

  // Square index is {row[2:0], col[2:0]}.
  function automatic logic [2:0] sq_row(input logic [5:0] sq);
    return sq[5:3];
  endfunction

  function automatic logic [2:0] sq_col(input logic [5:0] sq);
    return sq[2:0];
  endfunction

  function automatic logic [5:0] sq_make(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/move_select_ctrl_cursor_pos.sv
// Cursor register for move_select_ctrl: one-square steps with U > D > L > R priority.
// Define CURSOR_WRAP_EN to wrap modulo 8 per axis; otherwise the cursor saturates at the edges.
module cursor_pos
  import move_select_ctrl_pkg::*;
#(
  parameter logic [5:0] INIT = 6'o64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_up,
  input  logic       i_dn,
  input  logic       i_lt,
  input  logic       i_rt,
  output logic [5:0] o_addr
);

  logic [5:0] r_addr;
  logic [5:0] w_next;
  logic [2:0] w_row;
  logic [2:0] w_col;

  function automatic logic [2:0] axis_dec(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
    return v - 3'd1;
`else
    return (v == 3'd0) ? v : v - 3'd1;
`endif
  endfunction

  function automatic logic [2:0] axis_inc(input logic [2:0] v);
`ifdef CURSOR_WRAP_EN
    return v + 3'd1;
`else
    return (v == 3'd7) ? v : v + 3'd1;
`endif
  endfunction

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    w_row = sq_row(r_addr);
    w_col = sq_col(r_addr);
    if (i_en) begin
      if (i_up)      w_row = axis_dec(w_row);
      else if (i_dn) w_row = axis_inc(w_row);
      else if (i_lt) w_col = axis_dec(w_col);
      else if (i_rt) w_col = axis_inc(w_col);
    end
    w_next = sq_make(w_row, w_col);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_addr <= INIT;
    else     r_addr <= w_next;
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/move_select_ctrl.sv
// Cursor and move-selection controller: picks a source and destination square and
// issues one move per turn over a valid/ready handshake. Optional macro: CURSOR_WRAP_EN.
module move_select_ctrl
  import move_select_ctrl_pkg::*;
#(
  parameter logic [5:0] CURSOR_INIT = 6'b110_100,
  parameter logic       FIRST_TURN  = 1'b0
) (
  input  logic       ClkPort,
  input  logic       Reset,
  input  logic       BtnU_pulse,
  input  logic       BtnD_pulse,
  input  logic       BtnL_pulse,
  input  logic       BtnR_pulse,
  input  logic       BtnC_pulse,
  output logic [5:0] rd_addr,
  input  logic [3:0] rd_piece,
  output logic [5:0] cursor_addr,
  output logic [5:0] src_addr,
  output logic       src_valid,
  output logic       turn,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [5:0] mv_src,
  output logic [5:0] mv_dst,
  output logic [3:0] mv_piece
);

  state_t     r_state, w_state;
  logic [5:0] r_src_addr, w_src_addr;
  logic [3:0] r_src_piece, w_src_piece;
  logic       r_src_valid, w_src_valid;
  logic       r_turn, w_turn;
  logic       r_mv_valid, w_mv_valid;
  logic [5:0] r_mv_src, w_mv_src;
  logic [5:0] r_mv_dst, w_mv_dst;
  logic [3:0] r_mv_piece, w_mv_piece;

  logic [5:0] w_cursor;
  logic       w_cursor_en;
  logic       w_own_piece;

  // A confirm press wins over any direction press in the same cycle.
  assign w_cursor_en = (r_state != ISSUE) && !BtnC_pulse;

  cursor_pos #(
    .INIT (CURSOR_INIT)
  ) u_cursor_pos (
    .clk    (ClkPort),
    .rst    (Reset),
    .i_en   (w_cursor_en),
    .i_up   (BtnU_pulse),
    .i_dn   (BtnD_pulse),
    .i_lt   (BtnL_pulse),
    .i_rt   (BtnR_pulse),
    .o_addr (w_cursor)
  );

  assign w_own_piece = (rd_piece[2:0] != PIECE_NONE) && (rd_piece[3] == r_turn);

  always_comb begin
    w_state     = r_state;
    w_src_addr  = r_src_addr;
    w_src_piece = r_src_piece;
    w_src_valid = r_src_valid;
    w_turn      = r_turn;
    w_mv_valid  = r_mv_valid;
    w_mv_src    = r_mv_src;
    w_mv_dst    = r_mv_dst;
    w_mv_piece  = r_mv_piece;
    unique case (r_state)
      SEL_SRC: begin
        if (BtnC_pulse && w_own_piece) begin
          w_src_addr  = w_cursor;
          w_src_piece = rd_piece;
          w_src_valid = 1'b1;
          w_state     = SEL_DST;
        end
      end
      SEL_DST: begin
        if (BtnC_pulse) begin
          if (w_cursor == r_src_addr) begin
            w_src_valid = 1'b0;
            w_state     = SEL_SRC;
          end else if (w_own_piece) begin
            w_src_addr  = w_cursor;
            w_src_piece = rd_piece;
          end else begin
            w_mv_src   = r_src_addr;
            w_mv_dst   = w_cursor;
            w_mv_piece = r_src_piece;
            w_mv_valid = 1'b1;
            w_state    = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (r_mv_valid && mv_ready) begin
          w_mv_valid  = 1'b0;
          w_src_valid = 1'b0;
          w_turn      = ~r_turn;
          w_state     = SEL_SRC;
        end
      end
      default: w_state = SEL_SRC;
    endcase
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      r_state     <= SEL_SRC;
      r_src_addr  <= '0;
      r_src_piece <= '0;
      r_src_valid <= 1'b0;
      r_turn      <= FIRST_TURN;
      r_mv_valid  <= 1'b0;
      r_mv_src    <= '0;
      r_mv_dst    <= '0;
      r_mv_piece  <= '0;
    end else begin
      r_state     <= w_state;
      r_src_addr  <= w_src_addr;
      r_src_piece <= w_src_piece;
      r_src_valid <= w_src_valid;
      r_turn      <= w_turn;
      r_mv_valid  <= w_mv_valid;
      r_mv_src    <= w_mv_src;
      r_mv_dst    <= w_mv_dst;
      r_mv_piece  <= w_mv_piece;
    end
  end

  assign rd_addr     = w_cursor;
  assign cursor_addr = w_cursor;
  assign src_addr    = r_src_addr;
  assign src_valid   = r_src_valid;
  assign turn        = r_turn;
  assign mv_valid    = r_mv_valid;
  assign mv_src      = r_mv_src;
  assign mv_dst      = r_mv_dst;
  assign mv_piece    = r_mv_piece;

endmodule

// File: tb/tb_move_select_ctrl.sv
// Directed bench for move_select_ctrl: table-driven selection vectors plus hand-written
// handshake, capture, asynchronous-reset and board-edge sequences.
module tb_move_select_ctrl;

  logic       ClkPort = 1'b0;
  logic       Reset   = 1'b1;
  logic       BtnU_pulse = 1'b0, BtnD_pulse = 1'b0, BtnL_pulse = 1'b0;
  logic       BtnR_pulse = 1'b0, BtnC_pulse = 1'b0;
  logic       mv_ready = 1'b0;
  logic [5:0] rd_addr, cursor_addr, src_addr, mv_src, mv_dst;
  logic [3:0] rd_piece, mv_piece;
  logic       src_valid, turn, mv_valid;

  logic [3:0] board [64];
  assign rd_piece = board[rd_addr];

  int n_checks = 0;
  int n_errors = 0;

  always #5 ClkPort = ~ClkPort;

  move_select_ctrl dut (
    .ClkPort     (ClkPort),
    .Reset       (Reset),
    .BtnU_pulse  (BtnU_pulse),
    .BtnD_pulse  (BtnD_pulse),
    .BtnL_pulse  (BtnL_pulse),
    .BtnR_pulse  (BtnR_pulse),
    .BtnC_pulse  (BtnC_pulse),
    .rd_addr     (rd_addr),
    .rd_piece    (rd_piece),
    .cursor_addr (cursor_addr),
    .src_addr    (src_addr),
    .src_valid   (src_valid),
    .turn        (turn),
    .mv_valid    (mv_valid),
    .mv_ready    (mv_ready),
    .mv_src      (mv_src),
    .mv_dst      (mv_dst),
    .mv_piece    (mv_piece)
  );

  // Button bundle order {U, D, L, R, C}.
  localparam logic [4:0] B_0 = 5'b00000;
  localparam logic [4:0] B_U = 5'b10000;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_C = 5'b00001;

  typedef struct {
    logic [4:0] btn;
    logic [5:0] cur;
    logic       sv;
    logic [5:0] src;
    logic       mv;
    logic       trn;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [4:0] btn, input logic rdy);
    @(negedge ClkPort);
    {BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse} = btn;
    mv_ready = rdy;
    @(posedge ClkPort);
    #1;
    {BtnU_pulse, BtnD_pulse, BtnL_pulse, BtnR_pulse, BtnC_pulse} = B_0;
    mv_ready = 1'b0;
  endtask

  task automatic check_mv(input string tag, input logic v, input logic [5:0] s,
                          input logic [5:0] d, input logic [3:0] p);
    check({tag, " mv_valid"}, mv_valid, v);
    check({tag, " mv_src"}, mv_src, s);
    check({tag, " mv_dst"}, mv_dst, d);
    check({tag, " mv_piece"}, mv_piece, p);
  endtask

  initial begin
    logic [5:0] exp_r, exp_u, exp_l;

    for (int i = 0; i < 64; i++) board[i] = 4'h0;
    for (int c = 0; c < 8; c++) begin
      board[8 + c]  = 4'b1001;  // black pawns, row 1
      board[48 + c] = 4'b0001;  // white pawns, row 6
    end
    board[6'o53] = 4'b1010;     // black knight in front of the white pawns

    vecs[0]  = '{B_0,       6'o64, 1'b0, 6'o00, 1'b0, 1'b0};
    vecs[1]  = '{B_U,       6'o54, 1'b0, 6'o00, 1'b0, 1'b0};
    vecs[2]  = '{B_C,       6'o54, 1'b0, 6'o00, 1'b0, 1'b0};  // empty square
    vecs[3]  = '{B_L,       6'o53, 1'b0, 6'o00, 1'b0, 1'b0};
    vecs[4]  = '{B_C,       6'o53, 1'b0, 6'o00, 1'b0, 1'b0};  // opponent piece
    vecs[5]  = '{B_R,       6'o54, 1'b0, 6'o00, 1'b0, 1'b0};
    vecs[6]  = '{B_D,       6'o64, 1'b0, 6'o00, 1'b0, 1'b0};
    vecs[7]  = '{B_C,       6'o64, 1'b1, 6'o64, 1'b0, 1'b0};  // select e-pawn
    vecs[8]  = '{B_C,       6'o64, 1'b0, 6'o64, 1'b0, 1'b0};  // deselect
    vecs[9]  = '{B_C,       6'o64, 1'b1, 6'o64, 1'b0, 1'b0};
    vecs[10] = '{B_L,       6'o63, 1'b1, 6'o64, 1'b0, 1'b0};
    vecs[11] = '{B_C,       6'o63, 1'b1, 6'o63, 1'b0, 1'b0};  // re-latch own piece
    vecs[12] = '{B_R,       6'o64, 1'b1, 6'o63, 1'b0, 1'b0};
    vecs[13] = '{B_C,       6'o64, 1'b1, 6'o64, 1'b0, 1'b0};
    vecs[14] = '{B_U | B_L, 6'o54, 1'b1, 6'o64, 1'b0, 1'b0};  // U beats L
    vecs[15] = '{B_U,       6'o44, 1'b1, 6'o64, 1'b0, 1'b0};
    vecs[16] = '{B_C | B_D, 6'o44, 1'b1, 6'o64, 1'b1, 1'b0};  // C wins, D dropped

    // Reset state while Reset is held.
    #12;
    check("rst cursor", cursor_addr, 6'o64);
    check("rst src_valid", src_valid, 1'b0);
    check("rst turn", turn, 1'b0);
    check_mv("rst", 1'b0, 6'o00, 6'o00, 4'h0);
    @(negedge ClkPort);
    Reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].btn, 1'b0);
      check($sformatf("v%0d cursor", i), cursor_addr, vecs[i].cur);
      check($sformatf("v%0d rd_addr", i), rd_addr, vecs[i].cur);
      check($sformatf("v%0d src_valid", i), src_valid, vecs[i].sv);
      check($sformatf("v%0d src_addr", i), src_addr, vecs[i].src);
      check($sformatf("v%0d mv_valid", i), mv_valid, vecs[i].mv);
      check($sformatf("v%0d turn", i), turn, vecs[i].trn);
    end

    // ISSUE: move held stable while not ready, buttons ignored.
    check_mv("issue", 1'b1, 6'o64, 6'o44, 4'b0001);
    step(B_U, 1'b0);
    check_mv("hold1", 1'b1, 6'o64, 6'o44, 4'b0001);
    check("hold1 cursor", cursor_addr, 6'o44);
    step(B_R, 1'b0);
    check_mv("hold2", 1'b1, 6'o64, 6'o44, 4'b0001);
    check("hold2 cursor", cursor_addr, 6'o44);
    step(B_C, 1'b0);
    check_mv("hold3", 1'b1, 6'o64, 6'o44, 4'b0001);
    check("hold3 cursor", cursor_addr, 6'o44);
    check("hold3 turn", turn, 1'b0);
    step(B_0, 1'b1);
    check("hs mv_valid", mv_valid, 1'b0);
    check("hs turn", turn, 1'b1);
    check("hs src_valid", src_valid, 1'b0);
    step(B_0, 1'b1);
    check("idle ready turn", turn, 1'b1);
    check("idle ready mv_valid", mv_valid, 1'b0);

    // Black captures a white pawn.
    step(B_D, 1'b0);
    step(B_L, 1'b0);
    check("blk cursor", cursor_addr, 6'o53);
    step(B_C, 1'b0);
    check("blk src_valid", src_valid, 1'b1);
    check("blk src_addr", src_addr, 6'o53);
    step(B_D, 1'b0);
    step(B_C, 1'b0);
    check_mv("capture", 1'b1, 6'o53, 6'o63, 4'b1010);

    // Asynchronous reset mid-cycle with a pending move.
    #2;
    Reset = 1'b1;
    #1;
    check("arst cursor", cursor_addr, 6'o64);
    check("arst src_addr", src_addr, 6'o00);
    check("arst src_valid", src_valid, 1'b0);
    check("arst turn", turn, 1'b0);
    check_mv("arst", 1'b0, 6'o00, 6'o00, 4'h0);
    @(negedge ClkPort);
    Reset = 1'b0;

    // Board edges.
    for (int i = 0; i < 6; i++) step(B_U, 1'b0);
    check("edge row0", cursor_addr, 6'o04);
    for (int i = 0; i < 3; i++) step(B_R, 1'b0);
    check("edge col7", cursor_addr, 6'o07);
`ifdef CURSOR_WRAP_EN
    exp_r = 6'o00; exp_u = 6'o70; exp_l = 6'o77;
`else
    exp_r = 6'o07; exp_u = 6'o07; exp_l = 6'o06;
`endif
    step(B_R, 1'b0);
    check("edge R at col7", cursor_addr, exp_r);
    step(B_U, 1'b0);
    check("edge U at row0", cursor_addr, exp_u);
    step(B_L, 1'b0);
    check("edge L", cursor_addr, exp_l);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
